// File: rtl/lvds_word_aligner.sv
// Per-lane ISERDES word aligner: slips each lane until TRAIN_PATTERN is seen LOCK_COUNT times in a row.
// Define ALIGN_ERR_CNT_EN to add per-lane post-lock mismatch counters on err_cnt.
module lvds_word_aligner #(
    parameter int                   N_LANES       = 2,
    parameter int                   DIN_WIDTH     = 8,
    parameter logic [DIN_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
    parameter int                   SLIP_HOLDOFF  = 16,
    parameter int                   LOCK_COUNT    = 8,
    parameter int                   MAX_SLIPS     = 16
) (
    input  logic                           sample_clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [N_LANES*DIN_WIDTH-1:0]   data_in,
    output logic [N_LANES-1:0]             bitslip,
    output logic [N_LANES-1:0]             locked,
    output logic [N_LANES-1:0]             fail,
    output logic                           done
`ifdef ALIGN_ERR_CNT_EN
   ,output logic [N_LANES*16-1:0]          err_cnt
`endif
);

    localparam int HO_W = ($clog2(SLIP_HOLDOFF + 1) > 0) ? $clog2(SLIP_HOLDOFF + 1) : 1;
    localparam int MC_W = ($clog2(LOCK_COUNT + 1) > 0) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int SL_W = ($clog2(MAX_SLIPS + 1) > 0) ? $clog2(MAX_SLIPS + 1) : 1;

    localparam logic [HO_W-1:0] HOLD_INIT  = HO_W'(SLIP_HOLDOFF - 1);
    localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_COUNT - 1);
    localparam logic [SL_W-1:0] SLIP_MAX   = SL_W'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
    } state_t;

    logic [N_LANES-1:0] settled;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        state_t                state_q;
        logic [HO_W-1:0]       hold_q;
        logic [MC_W-1:0]       match_q;
        logic [SL_W-1:0]       slip_q;
        logic                  bitslip_q;
        logic                  locked_q;
        logic                  fail_q;
        logic [DIN_WIDTH-1:0]  word;

        assign word       = data_in[k*DIN_WIDTH +: DIN_WIDTH];
        assign bitslip[k] = bitslip_q;
        assign locked[k]  = locked_q;
        assign fail[k]    = fail_q;
        assign settled[k] = (state_q == S_LOCKED) || (state_q == S_FAIL);

        always_ff @(posedge sample_clk) begin
            if (!reset_n) begin
                state_q   <= S_IDLE;
                hold_q    <= '0;
                match_q   <= '0;
                slip_q    <= '0;
                bitslip_q <= 1'b0;
                locked_q  <= 1'b0;
                fail_q    <= 1'b0;
            end else if (start) begin
                state_q   <= S_WAIT;
                hold_q    <= HOLD_INIT;
                match_q   <= '0;
                slip_q    <= '0;
                bitslip_q <= 1'b0;
                locked_q  <= 1'b0;
                fail_q    <= 1'b0;
            end else begin
                bitslip_q <= 1'b0;
                case (state_q)
                    S_WAIT: begin
                        if (hold_q == '0) state_q <= S_CHECK;
                        else              hold_q  <= hold_q - 1'b1;
                    end
                    S_CHECK: begin
                        if (word == TRAIN_PATTERN) begin
                            match_q <= match_q + 1'b1;
                            if (match_q == MATCH_LAST) begin
                                state_q  <= S_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            match_q <= '0;
                            if (slip_q == SLIP_MAX) begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                            end else begin
                                // Pulse is raised on entry so it is high for exactly the SLIP cycle.
                                state_q   <= S_SLIP;
                                bitslip_q <= 1'b1;
                            end
                        end
                    end
                    S_SLIP: begin
                        slip_q  <= slip_q + 1'b1;
                        hold_q  <= HOLD_INIT;
                        state_q <= S_WAIT;
                    end
                    default: ;
                endcase
            end
        end

`ifdef ALIGN_ERR_CNT_EN
        logic [15:0] err_q;
        assign err_cnt[k*16 +: 16] = err_q;

        always_ff @(posedge sample_clk) begin
            if (!reset_n || start) begin
                err_q <= '0;
            end else if (state_q == S_LOCKED && word != TRAIN_PATTERN && err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
            end
        end
`endif
    end

    // done reflects the lane states of the previous cycle, so it trails the last lock by one edge.
    always_ff @(posedge sample_clk) begin
        if (!reset_n || start) done <= 1'b0;
        else                   done <= &settled;
    end

endmodule
